// File: rtl/cpu_timing_pkg.sv
// Shared beat encoding and default sizing for the W-phase timing generator.
package cpu_timing_pkg;

  localparam logic [1:0] BEAT_W1 = 2'd0;
  localparam logic [1:0] BEAT_W2 = 2'd1;
  localparam logic [1:0] BEAT_W3 = 2'd2;

  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam int unsigned CNT_WIDTH_DEF   = 16;

  typedef enum logic [1:0] {
    ST_W1 = BEAT_W1,
    ST_W2 = BEAT_W2,
    ST_W3 = BEAT_W3
  } beat_t;

endpackage

// File: rtl/qd_sync_edge.sv
// Synchronizes the asynchronous QD pushbutton and emits a one-cycle pulse
// on each rising edge of the synchronized level.
module qd_sync_edge
  import cpu_timing_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic t3,
  input  logic clr,
  input  logic qd,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;

  always_ff @(posedge t3 or negedge clr) begin
    if (!clr) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], qd};
      prev <= sync[SYNC_STAGES-1];
    end
  end

  assign pulse = sync[SYNC_STAGES-1] & ~prev;

endmodule

// File: rtl/timing_gen.sv
// Beat timing generator: W1/W2/W3 sequencing, run/halt control with
// single-step, and a count of completed instruction cycles.
module timing_gen
  import cpu_timing_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned CNT_WIDTH   = CNT_WIDTH_DEF
) (
  input  logic                 t3,
  input  logic                 clr,
  input  logic                 qd,
  input  logic                 step_mode,
  input  logic                 short,
  input  logic                 long,
  input  logic                 stop,
  output logic                 w1,
  output logic                 w2,
  output logic                 w3,
  output logic                 running,
  output logic [CNT_WIDTH-1:0] instr_cnt
);

  beat_t                beat, beat_n;
  logic                 run_n;
  logic [CNT_WIDTH-1:0] cnt_n;
  logic                 start;
  logic                 cyc_end;

  qd_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_qd (
    .t3    (t3),
    .clr   (clr),
    .qd    (qd),
    .pulse (start)
  );

  always_ff @(posedge t3 or negedge clr) begin
    if (!clr) begin
      beat      <= ST_W1;
      running   <= 1'b0;
      instr_cnt <= '0;
    end else begin
      beat      <= beat_n;
      running   <= run_n;
      instr_cnt <= cnt_n;
    end
  end

  // stop takes priority over both beat advance and cycle-end accounting
  always_comb begin
    beat_n  = beat;
    run_n   = running;
    cnt_n   = instr_cnt;
    cyc_end = 1'b0;
    if (running) begin
      if (stop) begin
        run_n = 1'b0;
      end else begin
        unique case (beat)
          ST_W1: begin
            if (short) cyc_end = 1'b1;
            else       beat_n  = ST_W2;
          end
          ST_W2: begin
            if (long) beat_n  = ST_W3;
            else      cyc_end = 1'b1;
          end
          ST_W3:   cyc_end = 1'b1;
          default: cyc_end = 1'b1;
        endcase
        if (cyc_end) begin
          beat_n = ST_W1;
          cnt_n  = instr_cnt + CNT_WIDTH'(1);
          if (step_mode) run_n = 1'b0;
        end
      end
    end else if (start) begin
      run_n = 1'b1;
    end
  end

  assign w1 = (beat == ST_W1);
  assign w2 = (beat == ST_W2);
  assign w3 = (beat == ST_W3);

endmodule

// File: tb/tb_timing_gen.sv
// Self-checking bench for timing_gen: behavioural model plus directed and random stimulus.
module tb_timing_gen;
  import cpu_timing_pkg::*;

  localparam int S  = int'(SYNC_STAGES_DEF);
  localparam int CW = 4;

  logic          t3 = 1'b0;
  logic          clr = 1'b0;
  logic          qd = 1'b0;
  logic          step_mode = 1'b0;
  logic          short = 1'b0;
  logic          long = 1'b0;
  logic          stop = 1'b0;
  logic          w1, w2, w3, running;
  logic [CW-1:0] instr_cnt;

  int vectors = 0;
  int miscompares = 0;

  timing_gen #(.SYNC_STAGES(S), .CNT_WIDTH(CW)) dut (
    .t3        (t3),
    .clr       (clr),
    .qd        (qd),
    .step_mode (step_mode),
    .short     (short),
    .long      (long),
    .stop      (stop),
    .w1        (w1),
    .w2        (w2),
    .w3        (w3),
    .running   (running),
    .instr_cnt (instr_cnt)
  );

  always #5 t3 = ~t3;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: beat as 1/2/3, qd sample history (newest first) for the start pulse
  int mbeat = 1;
  bit mrun  = 1'b0;
  int mcnt  = 0;
  bit qh[$];

  function automatic bit qsample(input int age);
    return (age < qh.size()) ? qh[age] : 1'b0;
  endfunction

  always @(posedge t3 or negedge clr) begin
    if (!clr) begin
      mbeat = 1;
      mrun  = 1'b0;
      mcnt  = 0;
      qh.delete();
    end else begin
      bit pulse;
      bit done;
      qh.push_front(qd);
      if (qh.size() > S + 2) void'(qh.pop_back());
      pulse = qsample(S) && !qsample(S + 1);
      done  = 1'b0;
      if (mrun) begin
        if (stop) mrun = 1'b0;
        else begin
          if (mbeat == 1)      begin if (short) done = 1'b1; else mbeat = 2; end
          else if (mbeat == 2) begin if (long) mbeat = 3; else done = 1'b1; end
          else                 done = 1'b1;
          if (done) begin
            mbeat = 1;
            mcnt  = (mcnt + 1) % (1 << CW);
            if (step_mode) mrun = 1'b0;
          end
        end
      end else if (pulse) mrun = 1'b1;
    end
  end

  always @(negedge t3) begin
    if (clr) begin
      check("w1", int'(w1), int'(mbeat == 1));
      check("w2", int'(w2), int'(mbeat == 2));
      check("w3", int'(w3), int'(mbeat == 3));
      check("running", int'(running), int'(mrun));
      check("instr_cnt", int'(instr_cnt), mcnt);
    end
  end

  task automatic edges(input int n);
    repeat (n) @(negedge t3);
  endtask

  task automatic pulse_qd();
    qd = 1'b1;
    edges(1);
    qd = 1'b0;
  endtask

  initial begin
    edges(2);
    check("reset_w1", int'(w1), 1);
    check("reset_running", int'(running), 0);
    check("reset_cnt", int'(instr_cnt), 0);
    clr = 1'b1;

    // basic start latency and W1/W2 alternation
    pulse_qd();
    edges(S - 1);
    check("latency_not_yet", int'(running), 0);
    edges(1);
    check("latency_running", int'(running), 1);
    check("latency_w1", int'(w1), 1);
    edges(4);
    check("alt_cnt", int'(instr_cnt), 2);
    check("alt_w1", int'(w1), 1);

    // long inserts W3; long in W1 is ignored
    long = 1'b1;
    edges(6);
    long = 1'b0;
    check("long_cnt", int'(instr_cnt), 4);

    // short held, with long also set: stays in W1
    short = 1'b1;
    long  = 1'b1;
    edges(5);
    check("short_w1", int'(w1), 1);
    check("short_cnt", int'(instr_cnt), 9);
    short = 1'b0;
    long  = 1'b0;

    // single step halts at the next cycle end; held qd yields one cycle
    step_mode = 1'b1;
    edges(2);
    check("step_halt", int'(running), 0);
    check("step_cnt", int'(instr_cnt), 10);
    qd = 1'b1;
    edges(20);
    qd = 1'b0;
    check("held_qd_cnt", int'(instr_cnt), 11);
    check("held_qd_halt", int'(running), 0);
    edges(4);

    // stop in W2, resume from W2; stop on W3->W1 edge
    step_mode = 1'b0;
    pulse_qd();
    edges(S);
    edges(1);
    stop = 1'b1;
    edges(1);
    stop = 1'b0;
    check("stop_w2", int'(w2), 1);
    check("stop_halt", int'(running), 0);
    check("stop_cnt", int'(instr_cnt), 11);
    pulse_qd();
    edges(S);
    edges(1);
    check("resume_cnt", int'(instr_cnt), 12);
    check("resume_w1", int'(w1), 1);
    long = 1'b1;
    edges(2);
    long = 1'b0;
    stop = 1'b1;
    edges(1);
    stop = 1'b0;
    check("stop_w3", int'(w3), 1);
    check("stop_w3_cnt", int'(instr_cnt), 12);

    // asynchronous clear between edges
    #2 clr = 1'b0;
    #1;
    check("async_w1", int'(w1), 1);
    check("async_running", int'(running), 0);
    check("async_cnt", int'(instr_cnt), 0);
    edges(1);
    clr = 1'b1;

    // counter wrap with short held
    short = 1'b1;
    pulse_qd();
    edges(S);
    check("wrap_start", int'(running), 1);
    edges(15);
    check("wrap_15", int'(instr_cnt), 15);
    edges(1);
    check("wrap_0", int'(instr_cnt), 0);
    short = 1'b0;

    // randomized traffic including occasional mid-cycle resets
    for (int i = 0; i < 3000; i++) begin
      @(negedge t3);
      if ($urandom_range(0, 399) == 0) begin
        #2 clr = 1'b0;
        @(negedge t3);
        clr = 1'b1;
      end
      qd    = ($urandom % 6) == 0;
      short = ($urandom % 4) == 0;
      long  = ($urandom % 3) == 0;
      stop  = ($urandom % 10) == 0;
      if (($urandom % 50) == 0) step_mode = ~step_mode;
    end

    edges(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
